// File: rtl/cim_pkg.sv
// Shared types and constants for the CIM sequencer: FSM state encoding, command
// op codes, default column count and per-beat address strides.
package cim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_CLEAR = 3'd2,
        ST_ACCUM = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam logic OP_WRITE   = 1'b0;
    localparam logic OP_COMPUTE = 1'b1;

    localparam int NUM_COLS_DEF = 8;

    // Weight rows are one word apart; activation beats step two words.
    localparam logic [31:0] WR_STRIDE  = 32'd4;
    localparam logic [31:0] ACC_STRIDE = 32'd8;

    function automatic logic [31:0] beat_addr(input logic [31:0] base,
                                              input logic [31:0] idx,
                                              input logic [31:0] stride);
        return base + idx * stride;
    endfunction

endpackage

// File: rtl/cim_perf_counter.sv
// Saturating busy-cycle counter; only instantiated by cim_seq_ctrl when
// CIM_SEQ_PERF_CNT_EN is defined.
module cim_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/cim_seq_ctrl.sv
// Command sequencer for a compute-in-memory macro: weight writes, clear/accumulate
// compute passes and result drain. Optional perf counter: CIM_SEQ_PERF_CNT_EN.
module cim_seq_ctrl
    import cim_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int NUM_COLS = NUM_COLS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_last,
    output logic             cim_cs,
    output logic             cim_web,
    output logic             cim_cimeb,
    output logic             cim_psum_eb,
    output logic             cim_rst_oreg,
    output logic [3:0]       cim_oreg,
    output logic [31:0]      cim_addr,
    output logic [31:0]      cim_wdata,
    input  logic [31:0]      cim_rdata,
    output logic             busy,
    output logic [31:0]      perf_cycles
);

    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

    state_t           state, state_nxt;
    logic [31:0]      base, base_nxt;
    logic [LEN_W-1:0] len, len_nxt;
    logic [LEN_W-1:0] beat, beat_nxt;
    logic [COL_W-1:0] col, col_nxt;
    logic             len_zero;
    logic             last_beat;

    assign len_zero  = (len == '0);
    // Widened compare so K = 2^LEN_W-1 cannot overflow the beat index.
    assign last_beat = (((LEN_W+1)'(beat) + (LEN_W+1)'(1)) == (LEN_W+1)'(len));
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            base  <= '0;
            len   <= '0;
            beat  <= '0;
            col   <= '0;
        end else begin
            state <= state_nxt;
            base  <= base_nxt;
            len   <= len_nxt;
            beat  <= beat_nxt;
            col   <= col_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        base_nxt     = base;
        len_nxt      = len;
        beat_nxt     = beat;
        col_nxt      = col;
        cmd_ready    = 1'b0;
        in_ready     = 1'b0;
        res_valid    = 1'b0;
        res_data     = '0;
        res_last     = 1'b0;
        cim_cs       = 1'b0;
        cim_web      = 1'b0;
        cim_cimeb    = 1'b1;
        cim_psum_eb  = 1'b0;
        cim_rst_oreg = 1'b0;
        cim_oreg     = '0;
        cim_addr     = '0;
        cim_wdata    = '0;

        case (state)
            ST_IDLE: begin
                // Held low while reset is asserted, even though state already reads IDLE.
                cmd_ready = rst_n;
                if (cmd_valid) begin
                    base_nxt  = cmd_addr;
                    len_nxt   = cmd_len;
                    beat_nxt  = '0;
                    col_nxt   = '0;
                    state_nxt = (cmd_op == OP_COMPUTE) ? ST_CLEAR : ST_WRITE;
                end
            end

            ST_WRITE: begin
                if (len_zero) begin
                    state_nxt = ST_IDLE;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        cim_cs    = 1'b1;
                        cim_web   = 1'b1;
                        cim_cimeb = 1'b1;
                        cim_addr  = beat_addr(base, 32'(beat), WR_STRIDE);
                        cim_wdata = in_data;
                        if (last_beat) begin
                            beat_nxt  = '0;
                            state_nxt = ST_IDLE;
                        end else begin
                            beat_nxt = beat + LEN_W'(1);
                        end
                    end
                end
            end

            ST_CLEAR: begin
                cim_cs       = 1'b1;
                cim_web      = 1'b0;
                cim_cimeb    = 1'b0;
                cim_rst_oreg = 1'b1;
                col_nxt      = '0;
                state_nxt    = len_zero ? ST_DRAIN : ST_ACCUM;
            end

            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cim_cs      = 1'b1;
                    cim_web     = 1'b0;
                    cim_cimeb   = 1'b0;
                    cim_psum_eb = 1'b1;
                    cim_addr    = beat_addr(base, 32'(beat), ACC_STRIDE);
                    cim_wdata   = in_data;
                    if (last_beat) begin
                        beat_nxt  = '0;
                        state_nxt = ST_DRAIN;
                    end else begin
                        beat_nxt = beat + LEN_W'(1);
                    end
                end
            end

            ST_DRAIN: begin
                cim_oreg  = 4'(col);
                res_valid = 1'b1;
                res_data  = cim_rdata;
                res_last  = (col == LAST_COL);
                if (res_ready) begin
                    if (col == LAST_COL) begin
                        col_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        col_nxt = col + COL_W'(1);
                    end
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef CIM_SEQ_PERF_CNT_EN
    cim_perf_counter #(.W(32)) u_perf (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (busy),
        .count (perf_cycles)
    );
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_cim_seq_ctrl.sv
// Directed bench for cim_seq_ctrl with a toy CIM macro: column c adds activation
// nibble c when bit 5 of weight byte 8*c is set.
module tb_cim_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_data = '0;
    logic        res_valid, res_ready = 1'b1, res_last;
    logic [31:0] res_data;
    logic        cim_cs, cim_web, cim_cimeb, cim_psum_eb, cim_rst_oreg;
    logic [3:0]  cim_oreg;
    logic [31:0] cim_addr, cim_wdata, cim_rdata;
    logic        busy;
    logic [31:0] perf_cycles;

    always #5 clk = ~clk;

    cim_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .cim_cs(cim_cs), .cim_web(cim_web), .cim_cimeb(cim_cimeb), .cim_psum_eb(cim_psum_eb),
        .cim_rst_oreg(cim_rst_oreg), .cim_oreg(cim_oreg), .cim_addr(cim_addr),
        .cim_wdata(cim_wdata), .cim_rdata(cim_rdata),
        .busy(busy), .perf_cycles(perf_cycles)
    );

    int total = 0, bad = 0, cyc = 0, cmd_cyc = 0, stray = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  mem [0:63] = '{default: 8'h00};
    logic [31:0] oreg_m [0:7] = '{default: 32'h0};
    assign cim_rdata = oreg_m[cim_oreg[2:0]];

    int          acc_cyc_q[$];
    logic [31:0] acc_addr_q[$], acc_wdata_q[$];
    logic [3:0]  acc_flags_q[$];   // {web, cimeb, psum_eb, rst_oreg}
    logic [31:0] res_data_q[$];
    logic        res_last_q[$];
    int          res_cyc_q[$];

    // Macro stand-in plus access/result recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid && cmd_ready) cmd_cyc = cyc;
            if (busy && cmd_ready) stray++;
            if (!cim_cs && (cim_psum_eb || cim_rst_oreg)) stray++;
            if (!busy && (cim_cs || in_ready || res_valid)) stray++;
            if (cim_cs) begin
                acc_cyc_q.push_back(cyc);
                acc_addr_q.push_back(cim_addr);
                acc_wdata_q.push_back(cim_wdata);
                acc_flags_q.push_back({cim_web, cim_cimeb, cim_psum_eb, cim_rst_oreg});
                if (cim_web && cim_cimeb)
                    for (int b = 0; b < 4; b++) mem[cim_addr[5:0] + 6'(b)] = cim_wdata[8*b +: 8];
                if (!cim_web && !cim_cimeb && cim_rst_oreg)
                    for (int c = 0; c < 8; c++) oreg_m[c] = '0;
                if (!cim_web && !cim_cimeb && cim_psum_eb)
                    for (int c = 0; c < 8; c++)
                        if (mem[8*c][5]) oreg_m[c] = oreg_m[c] + 32'(cim_wdata[4*c +: 4]);
            end
            if (res_valid && res_ready) begin
                res_data_q.push_back(res_data);
                res_last_q.push_back(res_last);
                res_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic clear_q();
        acc_cyc_q.delete(); acc_addr_q.delete(); acc_wdata_q.delete(); acc_flags_q.delete();
        res_data_q.delete(); res_last_q.delete(); res_cyc_q.delete();
    endtask

    task automatic issue_cmd(input logic op, input logic [31:0] addr, input logic [7:0] len);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_len = '0;
    endtask

    task automatic send_beat(input logic [31:0] d, input int gap);
        logic got;
        got = 1'b0;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1; in_data = d;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk); got = in_ready;
            @(posedge clk); #1;
            if (got) break;
        end
        in_valid = 1'b0; in_data = '0;
        total++;
        if (got !== 1'b1) begin bad++; $display("FAIL beat_timeout got=%b want=1", got); end
    endtask

    task automatic wait_idle(output int ic);
        logic idle;
        idle = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!busy) begin idle = 1'b1; break; end
        end
        ic = cyc;
        total++;
        if (idle !== 1'b1) begin bad++; $display("FAIL idle_timeout busy=%b want=0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if ({cmd_ready, in_ready, res_valid, res_last, cim_cs, cim_web, cim_cimeb, cim_psum_eb,
             cim_rst_oreg, busy} !== 10'b0000001000)
            begin bad++; $display("FAIL reset_ctrl got=%b want=0000001000", {cmd_ready, in_ready,
                res_valid, res_last, cim_cs, cim_web, cim_cimeb, cim_psum_eb, cim_rst_oreg, busy}); end
        total++;
        if ({cim_addr, cim_wdata, res_data, cim_oreg, perf_cycles} !== '0)
            begin bad++; $display("FAIL reset_data addr=%h wdata=%h res=%h oreg=%h perf=%h want 0",
                cim_addr, cim_wdata, res_data, cim_oreg, perf_cycles); end
        @(negedge clk); rst_n = 1'b1; #1;
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release cmd_ready=%b want=1", cmd_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        int ic;
        clear_q();
        issue_cmd(1'b0, 32'h0, 8'd2);
        send_beat(32'h20202020, 0);
        send_beat(32'h20202020, 0);
        wait_idle(ic);
        total++;
        if (acc_cyc_q.size() !== 2) begin bad++; $display("FAIL write_count got=%0d want=2", acc_cyc_q.size()); end
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({acc_addr_q[k], acc_wdata_q[k], acc_flags_q[k], 32'(acc_cyc_q[k])} !==
                {32'(4*k), 32'h20202020, 4'b1100, 32'(cmd_cyc + 1 + k)})
                begin bad++; $display("FAIL write_beat%0d addr=%h wdata=%h flags=%b cyc=%0d want addr=%h flags=1100 cyc=%0d",
                    k, acc_addr_q[k], acc_wdata_q[k], acc_flags_q[k], acc_cyc_q[k], 4*k, cmd_cyc + 1 + k); end
        end
        for (int b = 0; b < 8; b++) begin
            total++;
            if (mem[b] !== 8'h20) begin bad++; $display("FAIL write_mem%0d got=%h want=20", b, mem[b]); end
        end
    endtask

    task automatic test_compute();
        int ic;
        clear_q();
        issue_cmd(1'b1, 32'h0, 8'd1);
        send_beat(32'hFFFFFFFF, 0);
        wait_idle(ic);
        total++;
        if ({acc_cyc_q.size(), res_data_q.size()} !== {32'd2, 32'd8})
            begin bad++; $display("FAIL comp_count acc=%0d res=%0d want 2/8", acc_cyc_q.size(), res_data_q.size()); end
        total++;
        if ({acc_flags_q[0], 32'(acc_cyc_q[0])} !== {4'b0001, 32'(cmd_cyc + 1)})
            begin bad++; $display("FAIL comp_clear flags=%b cyc=%0d want 0001 cyc=%0d", acc_flags_q[0], acc_cyc_q[0], cmd_cyc + 1); end
        total++;
        if ({acc_flags_q[1], acc_addr_q[1], acc_wdata_q[1], 32'(acc_cyc_q[1])} !==
            {4'b0010, 32'h0, 32'hFFFFFFFF, 32'(cmd_cyc + 2)})
            begin bad++; $display("FAIL comp_accum flags=%b addr=%h wdata=%h cyc=%0d want 0010/0/ffffffff/%0d",
                acc_flags_q[1], acc_addr_q[1], acc_wdata_q[1], acc_cyc_q[1], cmd_cyc + 2); end
        for (int c = 0; c < 8; c++) begin
            total++;
            if ({res_data_q[c], res_last_q[c], 32'(res_cyc_q[c])} !==
                {(c == 0) ? 32'h0000000F : 32'h0, (c == 7), 32'(cmd_cyc + 3 + c)})
                begin bad++; $display("FAIL comp_col%0d data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d",
                    c, res_data_q[c], res_last_q[c], res_cyc_q[c], (c == 0) ? 32'hF : 32'h0, (c == 7), cmd_cyc + 3 + c); end
        end
    endtask

    task automatic test_stall();
        int ic;
        int exp_cyc [4];
        logic [31:0] exp_addr [4];
        clear_q();
        exp_cyc  = '{cmd_cyc, 0, 0, 0};
        issue_cmd(1'b1, 32'h0, 8'd3);
        exp_cyc  = '{cmd_cyc + 1, cmd_cyc + 2, cmd_cyc + 5, cmd_cyc + 6};
        exp_addr = '{32'h0, 32'h0, 32'h8, 32'h10};
        send_beat(32'h12345673, 0);
        send_beat(32'hABCDEF05, 2);
        send_beat(32'h0000000A, 0);
        wait_idle(ic);
        total++;
        if ({acc_cyc_q.size(), res_data_q.size()} !== {32'd4, 32'd8})
            begin bad++; $display("FAIL stall_count acc=%0d res=%0d want 4/8", acc_cyc_q.size(), res_data_q.size()); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({acc_flags_q[k], acc_addr_q[k], 32'(acc_cyc_q[k])} !==
                {(k == 0) ? 4'b0001 : 4'b0010, exp_addr[k], 32'(exp_cyc[k])})
                begin bad++; $display("FAIL stall_acc%0d flags=%b addr=%h cyc=%0d want addr=%h cyc=%0d",
                    k, acc_flags_q[k], acc_addr_q[k], acc_cyc_q[k], exp_addr[k], exp_cyc[k]); end
        end
        total++;
        if (res_cyc_q[0] !== cmd_cyc + 7)
            begin bad++; $display("FAIL stall_first_res cyc=%0d want=%0d", res_cyc_q[0], cmd_cyc + 7); end
        for (int c = 0; c < 8; c++) begin
            total++;
            if ({res_data_q[c], res_last_q[c]} !== {(c == 0) ? 32'h12 : 32'h0, (c == 7)})
                begin bad++; $display("FAIL stall_col%0d data=%h last=%b want data=%h last=%b",
                    c, res_data_q[c], res_last_q[c], (c == 0) ? 32'h12 : 32'h0, (c == 7)); end
        end
    endtask

    task automatic test_zero_len();
        int ic;
        clear_q();
        issue_cmd(1'b1, 32'h40, 8'd0);
        wait_idle(ic);
        total++;
        if ({acc_cyc_q.size(), res_data_q.size(), acc_flags_q[0], 32'(acc_cyc_q[0])} !==
            {32'd1, 32'd8, 4'b0001, 32'(cmd_cyc + 1)})
            begin bad++; $display("FAIL zero_comp acc=%0d res=%0d flags=%b cyc=%0d want 1/8/0001/%0d",
                acc_cyc_q.size(), res_data_q.size(), acc_flags_q[0], acc_cyc_q[0], cmd_cyc + 1); end
        for (int c = 0; c < 8; c++) begin
            total++;
            if ({res_data_q[c], res_last_q[c], 32'(res_cyc_q[c])} !== {32'h0, (c == 7), 32'(cmd_cyc + 2 + c)})
                begin bad++; $display("FAIL zero_col%0d data=%h last=%b cyc=%0d want 0/%b/%0d",
                    c, res_data_q[c], res_last_q[c], res_cyc_q[c], (c == 7), cmd_cyc + 2 + c); end
        end
        clear_q();
        issue_cmd(1'b0, 32'h10, 8'd0);
        wait_idle(ic);
        total++;
        if ({acc_cyc_q.size(), 32'(ic)} !== {32'd0, 32'(cmd_cyc + 2)})
            begin bad++; $display("FAIL zero_write acc=%0d idle_cyc=%0d want 0/%0d", acc_cyc_q.size(), ic, cmd_cyc + 2); end
    endtask

    task automatic test_reset_mid();
        int ic;
        logic [31:0] exp_perf;
        issue_cmd(1'b1, 32'h0, 8'd4);
        in_valid = 1'b1; in_data = 32'h00000009;
        @(posedge clk); #1;          // CLEAR
        @(posedge clk); #1;          // beat 0 taken, now beat 1 offered
        in_data = 32'h00000004;
        #1;
        total++;
        if ({cim_cs, cim_psum_eb, cim_addr} !== {1'b1, 1'b1, 32'h8})
            begin bad++; $display("FAIL mid_beat1 cs=%b psum=%b addr=%h want 1/1/8", cim_cs, cim_psum_eb, cim_addr); end
        #1; rst_n = 1'b0; #1;
        total++;
        if ({cmd_ready, in_ready, res_valid, cim_cs, cim_cimeb, cim_psum_eb, cim_rst_oreg, busy, cim_addr} !==
            {8'b00001000, 32'h0})
            begin bad++; $display("FAIL mid_reset ctrl=%b addr=%h want 00001000/0",
                {cmd_ready, in_ready, res_valid, cim_cs, cim_cimeb, cim_psum_eb, cim_rst_oreg, busy}, cim_addr); end
        in_valid = 1'b0; in_data = '0;
        @(negedge clk); rst_n = 1'b1; #1;
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_release cmd_ready=%b want=1", cmd_ready); end
        @(posedge clk); #1;
        clear_q();
        issue_cmd(1'b1, 32'h0, 8'd1);
        send_beat(32'h00000006, 0);
        wait_idle(ic);
        total++;
        if ({acc_cyc_q.size(), res_data_q.size(), acc_flags_q[0], acc_flags_q[1]} !==
            {32'd2, 32'd8, 4'b0001, 4'b0010})
            begin bad++; $display("FAIL post_count acc=%0d res=%0d want 2/8", acc_cyc_q.size(), res_data_q.size()); end
        for (int c = 0; c < 8; c++) begin
            total++;
            if ({res_data_q[c], res_last_q[c]} !== {(c == 0) ? 32'h6 : 32'h0, (c == 7)})
                begin bad++; $display("FAIL post_col%0d data=%h last=%b want data=%h last=%b",
                    c, res_data_q[c], res_last_q[c], (c == 0) ? 32'h6 : 32'h0, (c == 7)); end
        end
`ifdef CIM_SEQ_PERF_CNT_EN
        // busy since the reset: CLEAR + one ACCUM beat + eight DRAIN cycles
        exp_perf = 32'd10;
`else
        exp_perf = 32'd0;
`endif
        total++;
        if (perf_cycles !== exp_perf) begin bad++; $display("FAIL perf got=%0d want=%0d", perf_cycles, exp_perf); end
    endtask

    task automatic test_invariants();
        total++;
        if (stray !== 0) begin bad++; $display("FAIL stray_ctrl got=%0d want=0", stray); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_compute();
        test_stall();
        test_zero_len();
        test_reset_mid();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
